vie_mem_stage: RTL and testbench

- Memory stage: sits directly downstream of the execute stage and upstream of writeback.
- Latches the execute-stage result bus and waits a fixed number of cycles for data-SRAM read data on loads.
- Captures that data into a hold buffer so it survives writeback back-pressure.
- Presents the final result to writeback and a status bus for hazard/forwarding logic in issue.

---
 rtl/vie_mem_stage_if.sv | 51 +++++
 rtl/vie_mem_stage.sv | 172 +++++++++++++++++
 tb/tb_vie_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vie_mem_stage_if.sv
//------------------------------------------------------------------------------
// vie_mem_stage_if
//
// Purpose:
//    Groups the memory-stage pipeline buses into one bundle. The memory stage
//    itself connects through the slave modport. Whatever drives the execute
//    bus and consumes the writeback/status buses connects through the master
//    modport.
//
// Signals:
//    rsbus_i          [72:0]  execute result bus
//                             [72] valid, [71] is_load, [70:64] dest,
//                             [63:32] fixres, [31:0] pc
//    data_sram_rdata  [31:0]  data SRAM read data
//    wb_allowin               writeback can accept this cycle
//    ms_allowin               memory stage can accept rsbus_i this cycle
//    wbbus_o          [71:0]  writeback bus
//                             [71] valid, [70:64] dest, [63:32] result,
//                             [31:0] pc
//    mstatus_o        [40:0]  status for issue hazard/forwarding logic
//                             [40] ms_valid, [39] load data pending,
//                             [38:32] dest, [31:0] result
//------------------------------------------------------------------------------
interface vie_mem_stage_if;
   logic [72:0] rsbus_i;
   logic [31:0] data_sram_rdata;
   logic        wb_allowin;
   logic        ms_allowin;
   logic [71:0] wbbus_o;
   logic [40:0] mstatus_o;

   // Memory-stage side.
   modport slave (
      input  rsbus_i,
      input  data_sram_rdata,
      input  wb_allowin,
      output ms_allowin,
      output wbbus_o,
      output mstatus_o
   );

   // Pipeline-neighbour side: execute, data SRAM, writeback and issue.
   modport master (
      output rsbus_i,
      output data_sram_rdata,
      output wb_allowin,
      input  ms_allowin,
      input  wbbus_o,
      input  mstatus_o
   );
endinterface

// File: rtl/vie_mem_stage.sv
//------------------------------------------------------------------------------
// vie_mem_stage
//
// Purpose:
//    Pipeline memory stage between execute and writeback. It latches the
//    execute result bus. For loads it waits LOAD_LAT cycles, counted from the
//    entry cycle, for data-SRAM read data. It captures that data into a hold
//    buffer so the data survives writeback back-pressure. It then presents
//    the final result to writeback, and a status bus to issue.
//
// Parameters:
//    LOAD_LAT   cycles from a load's entry cycle until data_sram_rdata is
//               valid. The legal range is 1..4. With LOAD_LAT=1 a load
//               completes in its entry cycle.
//
// Ports:
//    clock      single clock; all state changes on its rising edge
//    reset      asynchronous reset, active low
//    ms_bus     vie_mem_stage_if.slave (rsbus_i, data_sram_rdata,
//               wb_allowin in; ms_allowin, wbbus_o, mstatus_o out)
//    perf_retire_cnt [31:0]  only when VIE_MS_PERF_EN is defined:
//                            number of writeback transfers (wraps)
//    perf_stall_cnt  [31:0]  only when VIE_MS_PERF_EN is defined:
//                            number of cycles a valid load waited for data
//
// Configuration macro:
//    VIE_MS_PERF_EN  adds the two performance counters. When it is undefined
//                    the counters and their ports do not exist, and all other
//                    behaviour is the same.
//------------------------------------------------------------------------------
module vie_mem_stage #(
   parameter int LOAD_LAT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   vie_mem_stage_if.slave        ms_bus
`ifdef VIE_MS_PERF_EN
   ,
   output logic [31:0]           perf_retire_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   // Counter value in the cycle where SRAM read data is valid.
   localparam logic [1:0] LAT_LAST = 2'(LOAD_LAT - 1);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic        r_ms_valid;
   logic        r_is_load;
   logic [6:0]  r_dest;
   logic [31:0] r_fixres;
   logic [31:0] r_pc;
   logic [1:0]  r_cnt;
   logic [31:0] r_rdata_buf;
   logic        r_buf_vld;

   //---------------------------------------------------------------------------
   // Combinational control
   //---------------------------------------------------------------------------
   logic        w_in_valid;
   logic        w_load_wait;
   logic        w_rdata_hit;
   logic        w_cnt_run;
   logic        w_ms_cango;
   logic        w_ms_allowin;
   logic        w_wb_valid;
   logic        w_load_pending;
   logic [31:0] w_result;

   assign w_in_valid  = ms_bus.rsbus_i[72];

   // A valid load whose data has not been captured yet.
   assign w_load_wait = r_ms_valid && r_is_load && !r_buf_vld;

   // The SRAM data is valid in exactly this cycle of the wait.
   assign w_rdata_hit = w_load_wait && (r_cnt == LAT_LAST);

   // The counter advances until it reaches the data cycle, then it holds.
   assign w_cnt_run   = w_load_wait && (r_cnt != LAT_LAST);

   assign w_ms_cango  = !r_is_load || r_buf_vld || w_rdata_hit;
   assign w_ms_allowin = !r_ms_valid || (w_ms_cango && ms_bus.wb_allowin);
   assign w_wb_valid  = r_ms_valid && w_ms_cango;
   assign w_load_pending = r_ms_valid && r_is_load && !w_ms_cango;

   // In the hit cycle the result comes straight from the SRAM, so a load
   // with LOAD_LAT=1 adds no stall. After that the buffer is the only source.
   // The SRAM may be re-driven while writeback stalls us, and the buffer
   // keeps the result stable through that.
   always_comb begin
      w_result = r_fixres;
      if (r_is_load) begin
         w_result = r_buf_vld ? r_rdata_buf : ms_bus.data_sram_rdata;
      end
   end

   //---------------------------------------------------------------------------
   // Pipeline register, wait counter and load-data hold buffer
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ms_valid  <= 1'b0;
         r_is_load   <= 1'b0;
         r_dest      <= '0;
         r_fixres    <= '0;
         r_pc        <= '0;
         r_cnt       <= '0;
         r_rdata_buf <= '0;
         r_buf_vld   <= 1'b0;
      end else begin
         if (w_ms_allowin) begin
            r_ms_valid <= w_in_valid;
         end

         if (w_in_valid && w_ms_allowin) begin
            // A new instruction enters. It replaces a retiring one in the
            // same cycle, so the load bookkeeping starts over.
            r_is_load <= ms_bus.rsbus_i[71];
            r_dest    <= ms_bus.rsbus_i[70:64];
            r_fixres  <= ms_bus.rsbus_i[63:32];
            r_pc      <= ms_bus.rsbus_i[31:0];
            r_cnt     <= '0;
            r_buf_vld <= 1'b0;
         end else begin
            if (w_cnt_run) begin
               r_cnt <= r_cnt + 2'd1;
            end
            // Capture even under back-pressure. Once r_buf_vld is set,
            // w_rdata_hit stays low, so later SRAM activity is ignored.
            if (w_rdata_hit) begin
               r_rdata_buf <= ms_bus.data_sram_rdata;
               r_buf_vld   <= 1'b1;
            end
         end
      end
   end

`ifdef VIE_MS_PERF_EN
   //---------------------------------------------------------------------------
   // Performance counters (free-running, wrap at 2^32)
   //---------------------------------------------------------------------------
   logic [31:0] r_perf_retire;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_perf_retire <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_wb_valid && ms_bus.wb_allowin) begin
            r_perf_retire <= r_perf_retire + 32'd1;
         end
         if (r_ms_valid && !w_ms_cango) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_retire_cnt = r_perf_retire;
   assign perf_stall_cnt  = r_perf_stall;
`endif

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign ms_bus.ms_allowin = w_ms_allowin;
   assign ms_bus.wbbus_o    = {w_wb_valid, r_dest, w_result, r_pc};
   assign ms_bus.mstatus_o  = {r_ms_valid, w_load_pending, r_dest, w_result};

endmodule

// File: tb/tb_vie_mem_stage.sv
//------------------------------------------------------------------------------
// tb_vie_mem_stage
//
// Two stage instances are built, one with LOAD_LAT=1 and one with LOAD_LAT=3.
// Each instance gets its own directed stimulus. A behavioural model tracks
// each instruction by its age in cycles since entry, and a negedge compare
// process checks both instances against the model on every cycle. Literal
// checks along the directed sequence pin the expected values by hand.
// With VIE_MS_PERF_EN defined, the performance counters are checked as well.
//------------------------------------------------------------------------------
module tb_vie_mem_stage;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int lat [2] = '{1, 3};

   logic [72:0] rs [2];
   logic [31:0] rd [2];
   logic        wa [2];

   vie_mem_stage_if if1 ();
   vie_mem_stage_if if3 ();

   assign if1.rsbus_i         = rs[0];
   assign if1.data_sram_rdata = rd[0];
   assign if1.wb_allowin      = wa[0];
   assign if3.rsbus_i         = rs[1];
   assign if3.data_sram_rdata = rd[1];
   assign if3.wb_allowin      = wa[1];

`ifdef VIE_MS_PERF_EN
   logic [31:0] pr [2];
   logic [31:0] ps [2];
`endif

   vie_mem_stage #(.LOAD_LAT(1)) u_lat1 (
      .clock  (clock),
      .reset  (reset),
      .ms_bus (if1)
`ifdef VIE_MS_PERF_EN
      ,
      .perf_retire_cnt (pr[0]),
      .perf_stall_cnt  (ps[0])
`endif
   );

   vie_mem_stage #(.LOAD_LAT(3)) u_lat3 (
      .clock  (clock),
      .reset  (reset),
      .ms_bus (if3)
`ifdef VIE_MS_PERF_EN
      ,
      .perf_retire_cnt (pr[1]),
      .perf_stall_cnt  (ps[1])
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Behavioural model. It keeps one slot per instance and the age of the
   // instruction in that slot. A load is ready once its age reaches
   // LOAD_LAT-1. The data seen at that age is remembered for later cycles.
   //---------------------------------------------------------------------------
   logic        m_v   [2];
   logic        m_ld  [2];
   logic [6:0]  m_dest[2];
   logic [31:0] m_fix [2];
   logic [31:0] m_pc  [2];
   int          m_age [2];
   logic [31:0] m_cap [2];
   logic [31:0] m_ret [2];
   logic [31:0] m_stl [2];

   function automatic logic m_ready(int k);
      return !m_ld[k] || (m_age[k] >= lat[k] - 1);
   endfunction

   function automatic logic [31:0] m_result(int k);
      if (!m_ld[k])              return m_fix[k];
      if (m_age[k] > lat[k] - 1) return m_cap[k];
      return rd[k];
   endfunction

   always @(posedge clock or negedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            m_v[k]   <= 1'b0;
            m_ld[k]  <= 1'b0;
            m_age[k] <= 0;
            m_ret[k] <= '0;
            m_stl[k] <= '0;
         end else begin
            if (m_v[k] && m_ready(k) && wa[k]) m_ret[k] <= m_ret[k] + 32'd1;
            if (m_v[k] && !m_ready(k))         m_stl[k] <= m_stl[k] + 32'd1;
            if (m_v[k] && m_ld[k] && m_age[k] == lat[k] - 1) m_cap[k] <= rd[k];
            m_age[k] <= m_age[k] + 1;
            if (!m_v[k] || (m_ready(k) && wa[k])) begin
               m_v[k] <= rs[k][72];
               if (rs[k][72]) begin
                  m_ld[k]   <= rs[k][71];
                  m_dest[k] <= rs[k][70:64];
                  m_fix[k]  <= rs[k][63:32];
                  m_pc[k]   <= rs[k][31:0];
                  m_age[k]  <= 0;
               end
            end
         end
      end
   end

   task automatic compare_inst(int k);
      logic [71:0] wb;
      logic [40:0] st;
      logic        al;
      logic        rdy;
      string       p;
      wb  = (k == 0) ? if1.wbbus_o    : if3.wbbus_o;
      st  = (k == 0) ? if1.mstatus_o  : if3.mstatus_o;
      al  = (k == 0) ? if1.ms_allowin : if3.ms_allowin;
      rdy = m_ready(k);
      p   = $sformatf("model_lat%0d", lat[k]);
      chk({p, "_allowin"}, 128'(al), 128'(!m_v[k] || (rdy && wa[k])));
      chk({p, "_wb_valid"}, 128'(wb[71]), 128'(m_v[k] && rdy));
      if (m_v[k] && rdy)
         chk({p, "_wb_payload"}, 128'(wb[70:0]), 128'({m_dest[k], m_result(k), m_pc[k]}));
      chk({p, "_st_flags"}, 128'(st[40:39]), 128'({m_v[k], m_v[k] && m_ld[k] && !rdy}));
      if (m_v[k])
         chk({p, "_st_payload"}, 128'(st[38:0]), 128'({m_dest[k], m_result(k)}));
`ifdef VIE_MS_PERF_EN
      chk({p, "_perf_retire"}, 128'(pr[k]), 128'(m_ret[k]));
      chk({p, "_perf_stall"},  128'(ps[k]), 128'(m_stl[k]));
`endif
   endtask

   always @(negedge clock) begin
      compare_inst(0);
      compare_inst(1);
   end

   //---------------------------------------------------------------------------
   // Directed stimulus. Inputs change 1 time unit after the rising edge.
   //---------------------------------------------------------------------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic neg();
      @(negedge clock);
   endtask

   function automatic logic [72:0] op(logic ld, logic [6:0] d, logic [31:0] f, logic [31:0] pc);
      return {1'b1, ld, d, f, pc};
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         rs[k] = '0;
         rd[k] = '0;
         wa[k] = 1'b1;
      end

      // Reset state.
      step();
      step();
      neg();
      chk("reset_allowin_l1", 128'(if1.ms_allowin), 128'(1'b1));
      chk("reset_wbbus_l1",   128'(if1.wbbus_o),    128'(0));
      chk("reset_mstatus_l1", 128'(if1.mstatus_o),  128'(0));
      chk("reset_allowin_l3", 128'(if3.ms_allowin), 128'(1'b1));
      chk("reset_wbbus_l3",   128'(if3.wbbus_o),    128'(0));
      chk("reset_mstatus_l3", 128'(if3.mstatus_o),  128'(0));
      step();
      reset = 1'b1;
      step();

      // ALU pass-through.
      rs[0] = op(1'b0, 7'd5, 32'h1234, 32'hBFC00000);
      step();
      rs[0] = '0;
      neg();
      chk("alu_wbbus", 128'(if1.wbbus_o), 128'({1'b1, 7'd5, 32'h1234, 32'hBFC00000}));
      chk("alu_allowin", 128'(if1.ms_allowin), 128'(1'b1));
      step();

      // Load with LOAD_LAT=1: completes in its entry cycle.
      rs[0] = op(1'b1, 7'd3, 32'h0, 32'hBFC00004);
      step();
      rs[0] = '0;
      rd[0] = 32'hDEADBEEF;
      neg();
      chk("ld1_wbbus", 128'(if1.wbbus_o), 128'({1'b1, 7'd3, 32'hDEADBEEF, 32'hBFC00004}));
      chk("ld1_pending", 128'(if1.mstatus_o[39]), 128'(1'b0));
      step();

      // Back-pressure hold: data captured on entry, SRAM later goes to 0.
      wa[0] = 1'b0;
      rs[0] = op(1'b1, 7'd4, 32'h0, 32'hBFC00008);
      step();
      rs[0] = '0;
      neg();
      chk("bp_entry_valid", 128'(if1.wbbus_o[71]), 128'(1'b1));
      chk("bp_entry_allowin", 128'(if1.ms_allowin), 128'(1'b0));
      step();
      rd[0] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("bp_hold_result", 128'(if1.wbbus_o[63:32]), 128'(32'hDEADBEEF));
         chk("bp_hold_allowin", 128'(if1.ms_allowin), 128'(1'b0));
         if (i < 3) step();
      end
      step();
      wa[0] = 1'b1;
      neg();
      chk("bp_release", 128'(if1.wbbus_o), 128'({1'b1, 7'd4, 32'hDEADBEEF, 32'hBFC00008}));
      step();
      neg();
      chk("bp_retire_once", 128'(if1.wbbus_o[71]), 128'(1'b0));
      step();

      // Back-to-back ALU ops: no bubbles between them.
      rs[0] = op(1'b0, 7'd10, 32'hA1, 32'h100);
      step();
      rs[0] = op(1'b0, 7'd11, 32'hA2, 32'h104);
      neg();
      chk("b2b_op1", 128'(if1.wbbus_o), 128'({1'b1, 7'd10, 32'hA1, 32'h100}));
      step();
      rs[0] = op(1'b0, 7'd12, 32'hA3, 32'h108);
      neg();
      chk("b2b_op2", 128'(if1.wbbus_o), 128'({1'b1, 7'd11, 32'hA2, 32'h104}));
      step();
      rs[0] = '0;
      neg();
      chk("b2b_op3", 128'(if1.wbbus_o), 128'({1'b1, 7'd12, 32'hA3, 32'h108}));
      step();
      neg();
      chk("b2b_drain", 128'(if1.wbbus_o[71]), 128'(1'b0));
      step();

      // Load with LOAD_LAT=3: two stall cycles, then data in cycle 3.
      // A new ALU op enters in the retire cycle.
      rs[1] = op(1'b1, 7'd7, 32'h0, 32'hBFC00100);
      rd[1] = 32'h11111111;
      step();
      rs[1] = '0;
      for (int i = 0; i < 2; i++) begin
         neg();
         chk("ld3_wait_allowin", 128'(if3.ms_allowin), 128'(1'b0));
         chk("ld3_wait_pending", 128'(if3.mstatus_o[39]), 128'(1'b1));
         chk("ld3_wait_valid", 128'(if3.wbbus_o[71]), 128'(1'b0));
         step();
      end
      rd[1] = 32'hCAFEF00D;
      rs[1] = op(1'b0, 7'd8, 32'h5555, 32'hBFC00104);
      neg();
      chk("ld3_done", 128'(if3.wbbus_o), 128'({1'b1, 7'd7, 32'hCAFEF00D, 32'hBFC00100}));
      chk("ld3_done_allowin", 128'(if3.ms_allowin), 128'(1'b1));
      step();
      rs[1] = '0;
      rd[1] = '0;
      neg();
      chk("ld3_follow_alu", 128'(if3.wbbus_o), 128'({1'b1, 7'd8, 32'h5555, 32'hBFC00104}));
      step();

      // Reset asserted while a load waits.
      rs[1] = op(1'b1, 7'd9, 32'h0, 32'hBFC00200);
      step();
      rs[1] = '0;
      neg();
      chk("rst_pre_pending", 128'(if3.mstatus_o[39]), 128'(1'b1));
      #2;
      reset = 1'b0;
      #1;
      chk("rst_wbbus", 128'(if3.wbbus_o), 128'(0));
      chk("rst_mstatus", 128'(if3.mstatus_o), 128'(0));
      chk("rst_allowin", 128'(if3.ms_allowin), 128'(1'b1));
`ifdef VIE_MS_PERF_EN
      chk("rst_perf_retire_l1", 128'(pr[0]), 128'(0));
      chk("rst_perf_stall_l1",  128'(ps[0]), 128'(0));
      chk("rst_perf_retire_l3", 128'(pr[1]), 128'(0));
      chk("rst_perf_stall_l3",  128'(ps[1]), 128'(0));
`endif
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("rst_no_stale", 128'(if3.wbbus_o[71]), 128'(1'b0));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
